systolic_array_stream: RTL and testbench

//  Input-stationary HEIGHT x WIDTH systolic matrix-vector engine with its own sequencer and valid/ready streams.

---
 rtl/systolic_array_stream.sv | 217 +++++++++++++++++++++
 tb/tb_systolic_array_stream.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_stream.sv
// Input-stationary HEIGHT x WIDTH matrix-vector engine: o[r] = sum_c S[r][c]*w[c], with load/stream sequencer.
// Latency: ARRAY_WIDTH + ARRAY_HEIGHT advancing cycles from weight handshake to o_valid; 1 vector/cycle.
// Backpressure: o_valid & ~o_ready freezes every pipeline stage globally and drops w_ready.
module systolic_array_stream #(
    parameter int INPUT_WIDTH  = 16,
    parameter int WEIGHT_WIDTH = 16,
    parameter int PSUM_WIDTH   = 32,
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter bit SATURATE     = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ld_valid,
    output logic                                ld_ready,
    input  logic [ARRAY_WIDTH*INPUT_WIDTH-1:0]  ld_data,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic [ARRAY_WIDTH*WEIGHT_WIDTH-1:0] w_data,
    input  logic                                w_last,
    output logic                                o_valid,
    input  logic                                o_ready,
    output logic [ARRAY_HEIGHT*PSUM_WIDTH-1:0]  o_data,
    output logic                                o_last,
    output logic                                busy
);
    localparam int H   = ARRAY_HEIGHT;
    localparam int W   = ARRAY_WIDTH;
    localparam int PW  = PSUM_WIDTH;
    localparam int PRW = INPUT_WIDTH + WEIGHT_WIDTH;
    localparam int LAT = W + H;
    localparam int RCW = (H > 1) ? $clog2(H) : 1;
    localparam int XW  = ((PRW > PW) ? PRW : PW) + 1;

    localparam logic signed [PW-1:0] PS_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic signed [PW-1:0] PS_MIN = {1'b1, {(PW-1){1'b0}}};

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOAD   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    logic [1:0]     state;
    logic           loaded;
    logic [RCW-1:0] row_cnt;
    logic [RCW-1:0] ld_row;
    logic           adv, ld_fire, w_fire;

    logic signed [INPUT_WIDTH-1:0]  s_reg   [H][W];
    logic signed [WEIGHT_WIDTH-1:0] w_in    [W];
    logic signed [WEIGHT_WIDTH-1:0] col_in  [W];
    logic signed [WEIGHT_WIDTH-1:0] wp      [H][W];
    logic signed [PW-1:0]           ps      [H][W];
    logic signed [PW-1:0]           ps_nxt  [H][W];
    logic signed [PW-1:0]           row_out [H];
    logic [LAT-1:0]                 vld_pipe, last_pipe;

    // Product narrowed to psum width: wraps, or clamps when saturating.
    function automatic logic signed [PW-1:0] fit_prod(input logic signed [PRW-1:0] p);
        logic signed [XW-1:0] pe;
        pe = XW'(p);
        if (SATURATE && (pe > XW'(PS_MAX))) return PS_MAX;
        if (SATURATE && (pe < XW'(PS_MIN))) return PS_MIN;
        return PW'(pe);
    endfunction

    // Psum add with optional clamp on signed overflow.
    function automatic logic signed [PW-1:0] sat_add(input logic signed [PW-1:0] a,
                                                     input logic signed [PW-1:0] b);
        logic signed [PW:0] s;
        s = (PW+1)'(a) + (PW+1)'(b);
        if (SATURATE && (s[PW] != s[PW-1])) return s[PW] ? PS_MIN : PS_MAX;
        return s[PW-1:0];
    endfunction

    assign adv      = ~(o_valid & ~o_ready);
    assign ld_ready = (state == ST_IDLE) || (state == ST_LOAD);
    assign ld_fire  = ld_valid & ld_ready;
    assign w_fire   = w_valid & w_ready;
    assign busy     = (state != ST_IDLE);
    assign ld_row   = (state == ST_IDLE) ? '0 : row_cnt;
    assign o_valid  = vld_pipe[LAT-1];
    assign o_last   = vld_pipe[LAT-1] & last_pipe[LAT-1];

    // Weight acceptance: a pending load beats a weight in IDLE; streaming follows the stall.
    always_comb begin
        w_ready = 1'b0;
        case (state)
            ST_IDLE:   w_ready = loaded & ~ld_valid & adv;
            ST_STREAM: w_ready = adv;
            default:   w_ready = 1'b0;
        endcase
    end

    // Sequencer: row loading, streaming until w_last, drain until o_last leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            loaded  <= 1'b0;
            row_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ld_fire) begin
                        if (H == 1) begin
                            loaded <= 1'b1;
                        end else begin
                            loaded  <= 1'b0;
                            row_cnt <= RCW'(1);
                            state   <= ST_LOAD;
                        end
                    end else if (w_fire) begin
                        state <= w_last ? ST_DRAIN : ST_STREAM;
                    end
                end
                ST_LOAD: begin
                    if (ld_fire) begin
                        if (row_cnt == RCW'(H-1)) begin
                            loaded <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            row_cnt <= row_cnt + RCW'(1);
                        end
                    end
                end
                ST_STREAM: if (w_fire && w_last) state <= ST_DRAIN;
                ST_DRAIN:  if (o_valid && o_ready && o_last) state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Stationary matrix capture, one row per load beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    s_reg[r][c] <= '0;
        end else if (ld_fire) begin
            for (int c = 0; c < W; c++)
                s_reg[ld_row][c] <= ld_data[c*INPUT_WIDTH +: INPUT_WIDTH];
        end
    end

    // Entry skew: column c waits c stages so it meets its row's psum wavefront.
    for (genvar c = 0; c < W; c++) begin : g_skew
        assign w_in[c] = w_fire ? w_data[c*WEIGHT_WIDTH +: WEIGHT_WIDTH] : '0;
        if (c == 0) begin : g_direct
            assign col_in[c] = w_in[c];
        end else begin : g_chain
            logic signed [WEIGHT_WIDTH-1:0] sk [c];
            // Advance the column delay line with the global stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < c; k++) sk[k] <= '0;
                end else if (adv) begin
                    sk[0] <= w_in[c];
                    for (int k = 1; k < c; k++) sk[k] <= sk[k-1];
                end
            end
            assign col_in[c] = sk[c-1];
        end
    end

    // PE combinational step: psum enters column 0 as zero and accumulates rightwards.
    always_comb begin
        for (int r = 0; r < H; r++) begin
            ps_nxt[r][0] = sat_add('0, fit_prod(PRW'(s_reg[r][0]) * PRW'(wp[r][0])));
            for (int c = 1; c < W; c++)
                ps_nxt[r][c] = sat_add(ps[r][c-1], fit_prod(PRW'(s_reg[r][c]) * PRW'(wp[r][c])));
        end
    end

    // PE registers: weights flow down, psums flow right, valid/last ride alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    wp[r][c] <= '0;
                    ps[r][c] <= '0;
                end
        end else if (adv) begin
            vld_pipe  <= {vld_pipe[LAT-2:0], w_fire};
            last_pipe <= {last_pipe[LAT-2:0], w_fire & w_last};
            for (int c = 0; c < W; c++) wp[0][c] <= col_in[c];
            for (int r = 1; r < H; r++)
                for (int c = 0; c < W; c++)
                    wp[r][c] <= wp[r-1][c];
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    ps[r][c] <= ps_nxt[r][c];
        end
    end

    // Exit unskew: row r waits H-1-r stages so all rows leave together.
    for (genvar r = 0; r < H; r++) begin : g_unskew
        if (r == H-1) begin : g_direct
            assign row_out[r] = ps[r][W-1];
        end else begin : g_chain
            localparam int D = H - 1 - r;
            logic signed [PW-1:0] us [D];
            // Advance the row delay line with the global stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < D; k++) us[k] <= '0;
                end else if (adv) begin
                    us[0] <= ps[r][W-1];
                    for (int k = 1; k < D; k++) us[k] <= us[k-1];
                end
            end
            assign row_out[r] = us[D-1];
        end
        assign o_data[r*PW +: PW] = row_out[r];
    end
endmodule

// File: tb/tb_systolic_array_stream.sv
module tb_systolic_array_stream;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ld_valid = 1'b0, w_valid = 1'b0, w_last = 1'b0, o_ready = 1'b1;
    logic [63:0] ld_data = '0, w_data = '0;
    wire ld_ready, w_ready, o_valid, o_last, busy;
    wire [127:0] o_data;
    wire ld_ready_s, w_ready_s, o_valid_s, o_last_s, busy_s;
    wire [63:0] o_data_s;
    wire ld_ready_w, w_ready_w, o_valid_w, o_last_w, busy_w;
    wire [63:0] o_data_w;

    always #5 clk = ~clk;

    systolic_array_stream dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .busy(busy));

    systolic_array_stream #(.PSUM_WIDTH(16), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready_s), .ld_data(ld_data),
        .w_valid(w_valid), .w_ready(w_ready_s), .w_data(w_data), .w_last(w_last),
        .o_valid(o_valid_s), .o_ready(o_ready), .o_data(o_data_s), .o_last(o_last_s), .busy(busy_s));

    systolic_array_stream #(.PSUM_WIDTH(16), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready_w), .ld_data(ld_data),
        .w_valid(w_valid), .w_ready(w_ready_w), .w_data(w_data), .w_last(w_last),
        .o_valid(o_valid_w), .o_ready(o_ready), .o_data(o_data_w), .o_last(o_last_w), .busy(busy_w));

    int n_chk = 0, n_pass = 0, cyc = 0;
    int smat [4][4];
    bit rnd_done;
    logic [127:0] exp_d[$], obs_d[$];
    logic [63:0]  exp_s[$], obs_s[$], exp_w[$], obs_w[$];
    bit           exp_l[$], obs_l[$];
    int           obs_c[$], acc_c[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output handshake and every weight handshake, mid-cycle.
    always @(negedge clk) begin
        if (rst_n && o_valid && o_ready) begin
            obs_d.push_back(o_data); obs_l.push_back(o_last);
            obs_s.push_back(o_data_s); obs_w.push_back(o_data_w);
            obs_c.push_back(cyc);
        end
        if (rst_n && w_valid && w_ready) acc_c.push_back(cyc);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: signed arithmetic narrowed to pw bits by wrapping or clamping.
    function automatic longint fitv(longint v, int pw, bit sat);
        longint mx, mn, m;
        mx = (longint'(1) <<< (pw-1)) - 1;
        mn = -(longint'(1) <<< (pw-1));
        if (sat) begin
            if (v > mx) return mx;
            if (v < mn) return mn;
            return v;
        end
        m = v & ((longint'(1) <<< pw) - 1);
        if (m > mx) m = m - (longint'(1) <<< pw);
        return m;
    endfunction

    function automatic longint model_row(int r, logic [63:0] v, int pw, bit sat);
        longint acc, p;
        logic signed [15:0] wc;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            wc = v[c*16 +: 16];
            p = longint'(smat[r][c]) * longint'(wc);
            acc = fitv(acc + fitv(p, pw, sat), pw, sat);
        end
        return acc;
    endfunction

    function automatic logic [127:0] exp_main(logic [63:0] v);
        logic [127:0] e;
        longint t;
        for (int r = 0; r < 4; r++) begin
            t = model_row(r, v, 32, 1'b0);
            e[r*32 +: 32] = t[31:0];
        end
        return e;
    endfunction

    function automatic logic [63:0] exp16(logic [63:0] v, bit sat);
        logic [63:0] e;
        longint t;
        for (int r = 0; r < 4; r++) begin
            t = model_row(r, v, 16, sat);
            e[r*16 +: 16] = t[15:0];
        end
        return e;
    endfunction

    function automatic logic [63:0] pack_row(int r);
        logic [63:0] v;
        for (int c = 0; c < 4; c++) v[c*16 +: 16] = 16'(smat[r][c]);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr();
        exp_d.delete(); obs_d.delete(); exp_s.delete(); obs_s.delete();
        exp_w.delete(); obs_w.delete(); exp_l.delete(); obs_l.delete();
        obs_c.delete(); acc_c.delete();
    endtask

    task automatic rand_s();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                smat[r][c] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    task automatic load_s();
        bit ok;
        for (int r = 0; r < 4; r++) begin
            ld_data = pack_row(r); ld_valid = 1'b1; ok = 1'b0;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk); if (ld_ready) ok = 1'b1;
                tick();
            end
            if (!ok) begin n_chk++; $display("FAIL load_timeout: row %0d ld_ready never high", r); end
        end
        ld_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] v, input bit last);
        bit ok;
        w_data = v; w_last = last; w_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk); if (w_ready) ok = 1'b1;
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        if (ok) begin
            exp_d.push_back(exp_main(v)); exp_s.push_back(exp16(v, 1'b1));
            exp_w.push_back(exp16(v, 1'b0)); exp_l.push_back(last);
        end else begin
            n_chk++; $display("FAIL send_timeout: w_ready never high");
        end
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 2000 && obs_d.size() < n; i++) tick();
        if (obs_d.size() < n) begin
            n_chk++; $display("FAIL out_timeout: got %0d results want %0d", obs_d.size(), n);
        end
    endtask

    task automatic test_reset();
        #12;
        n_chk++; if (o_valid !== 1'b0) $display("FAIL rst_o_valid: got %b want 0", o_valid); else n_pass++;
        n_chk++; if (o_data !== 128'd0) $display("FAIL rst_o_data: got %h want 0", o_data); else n_pass++;
        n_chk++; if (o_last !== 1'b0) $display("FAIL rst_o_last: got %b want 0", o_last); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (ld_ready !== 1'b1) $display("FAIL rst_ld_ready: got %b want 1", ld_ready); else n_pass++;
        @(posedge clk); #3; rst_n = 1'b1;
        w_valid = 1'b1; w_data = 64'h0004_0003_0002_0001;
        @(negedge clk);
        n_chk++; if (w_ready !== 1'b0) $display("FAIL rst_w_ready_unloaded: got %b want 0", w_ready); else n_pass++;
        tick(); w_valid = 1'b0;
    endtask

    task automatic test_identity();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) smat[r][c] = (r == c) ? 1 : 0;
        load_s();
        @(negedge clk);
        n_chk++; if (w_ready !== 1'b1 || busy !== 1'b0) $display("FAIL id_loaded: got w_ready %b busy %b want 1 0", w_ready, busy); else n_pass++;
        tick(); clr();
        send_w(64'h0004_0003_0002_0001, 1'b1);
        wait_obs(1);
        n_chk++; if (obs_d[0] !== 128'h00000004_00000003_00000002_00000001 || obs_l[0] !== 1'b1)
            $display("FAIL id_data: got %h/%b want 4,3,2,1/1", obs_d[0], obs_l[0]); else n_pass++;
        n_chk++; if (obs_c[0] - acc_c[0] !== 8) $display("FAIL id_latency: got %0d want 8", obs_c[0] - acc_c[0]); else n_pass++;
        tick(); @(negedge clk);
        n_chk++; if (busy !== 1'b0) $display("FAIL id_idle_after: busy %b want 0", busy); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) smat[r][c] = r + 1;
        load_s(); clr();
        send_w(64'h0001_0001_0001_0001, 1'b0);
        send_w(64'hFFFF_0000_0000_0002, 1'b1);
        wait_obs(2);
        n_chk++; if (obs_d[0] !== 128'h00000010_0000000C_00000008_00000004) $display("FAIL b2b_first: got %h want 16,12,8,4", obs_d[0]); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i])
                $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        n_chk++; if (obs_c[1] - obs_c[0] !== 1 || acc_c[1] - acc_c[0] !== 1)
            $display("FAIL b2b_spacing: got out gap %0d in gap %0d want 1 1", obs_c[1] - obs_c[0], acc_c[1] - acc_c[0]); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        logic [127:0] snap;
        bit ok;
        rand_s(); load_s(); clr();
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_w({$urandom, $urandom}, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (o_valid) ok = 1'b1; end
        if (!ok) begin n_chk++; $display("FAIL stall_timeout: o_valid never high"); end
        snap = o_data;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (o_valid !== 1'b1 || w_ready !== 1'b0 || o_data !== snap)
                $display("FAIL stall_hold[%0d]: got vld %b w_ready %b data %h want 1 0 %h", i, o_valid, w_ready, o_data, snap);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++; if (obs_d.size() !== 0) $display("FAIL stall_leak: got %0d results want 0", obs_d.size()); else n_pass++;
        tick(); o_ready = 1'b1;
        send_w({$urandom, $urandom}, 1'b1);
        wait_obs(4);
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i])
                $display("FAIL stall_data[%0d]: got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_random();
        rand_s(); load_s(); clr();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_w({$urandom, $urandom}, i == 7);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin tick(); o_ready = 1'($urandom_range(0, 1)); end
                o_ready = 1'b1;
            end
        join
        wait_obs(8);
        for (int i = 0; i < 8; i++) begin
            n_chk++;
            if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i])
                $display("FAIL rand_data[%0d]: got %h/%b want %h/%b", i, obs_d[i], obs_l[i], exp_d[i], exp_l[i]);
            else n_pass++;
        end
        tick();
    endtask

    task automatic test_saturate();
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) smat[r][c] = 32767;
        load_s(); clr();
        send_w({4{16'h7FFF}}, 1'b0);
        send_w({4{16'h8000}}, 1'b1);
        wait_obs(2);
        n_chk++; if (obs_s[0] !== {4{16'h7FFF}}) $display("FAIL sat_pos: got %h want all 7fff", obs_s[0]); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if (obs_s[i] !== exp_s[i]) $display("FAIL sat_clamp[%0d]: got %h want %h", i, obs_s[i], exp_s[i]); else n_pass++;
            n_chk++; if (obs_w[i] !== exp_w[i]) $display("FAIL sat_wrap16[%0d]: got %h want %h", i, obs_w[i], exp_w[i]); else n_pass++;
            n_chk++; if (obs_d[i] !== exp_d[i]) $display("FAIL sat_wrap32[%0d]: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
        end
        tick();
    endtask

    task automatic test_tie();
        logic [63:0] v;
        bit ok;
        rand_s(); clr();
        v = {$urandom, $urandom};
        w_valid = 1'b1; w_data = v; w_last = 1'b1;
        for (int r = 0; r < 4; r++) begin
            ld_valid = 1'b1; ld_data = pack_row(r);
            @(negedge clk);
            n_chk++;
            if (ld_ready !== 1'b1 || w_ready !== 1'b0)
                $display("FAIL tie_row%0d: got ld_ready %b w_ready %b want 1 0", r, ld_ready, w_ready);
            else n_pass++;
            tick();
        end
        ld_valid = 1'b0; ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (w_ready) ok = 1'b1; tick(); end
        w_valid = 1'b0; w_last = 1'b0;
        if (!ok) begin n_chk++; $display("FAIL tie_timeout: w_ready never high"); end
        exp_d.push_back(exp_main(v)); exp_l.push_back(1'b1);
        wait_obs(1);
        n_chk++;
        if (obs_d[0] !== exp_d[0] || obs_l[0] !== 1'b1)
            $display("FAIL tie_data: got %h/%b want %h/1", obs_d[0], obs_l[0], exp_d[0]);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        bit any_rdy;
        rand_s(); load_s(); clr();
        send_w({$urandom, $urandom}, 1'b0);
        send_w({$urandom, $urandom}, 1'b0);
        tick(); #2; rst_n = 1'b0; #1;
        n_chk++; if (o_valid !== 1'b0 || o_last !== 1'b0 || o_data !== 128'd0)
            $display("FAIL mid_rst_out: got vld %b last %b data %h want 0 0 0", o_valid, o_last, o_data); else n_pass++;
        n_chk++; if (busy !== 1'b0 || w_ready !== 1'b0 || ld_ready !== 1'b1)
            $display("FAIL mid_rst_ctrl: got busy %b w_ready %b ld_ready %b want 0 0 1", busy, w_ready, ld_ready); else n_pass++;
        tick(); tick(); rst_n = 1'b1; clr();
        w_valid = 1'b1; w_data = {$urandom, $urandom}; any_rdy = 1'b0;
        for (int i = 0; i < 15; i++) begin @(negedge clk); if (w_ready) any_rdy = 1'b1; tick(); end
        w_valid = 1'b0;
        n_chk++; if (any_rdy !== 1'b0) $display("FAIL mid_rst_w_ready: got 1 want 0 until reload"); else n_pass++;
        n_chk++; if (obs_d.size() !== 0) $display("FAIL mid_rst_ghost: got %0d results want 0", obs_d.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_stall();
        test_random();
        test_saturate();
        test_tie();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
